// File: rtl/seq_det_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_det_pkg                                                  |
// | Description : Shared defaults, width helper and overlap-mode enum for the  |
// |               programmable serial sequence detector.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package seq_det_pkg;

    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_CNT_W   = 8;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } ovl_mode_e;

endpackage
`default_nettype wire

// File: rtl/seq_det_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_det_param_if                                             |
// | Description : Stream, configuration and result bundle of seq_det_param.    |
// |               match_cnt exists only when SEQ_DET_MATCH_CNT_EN is defined.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface seq_det_param_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = len_width(MAX_LEN),
    parameter int CNT_W   = DEFAULT_CNT_W
) ();

    logic               din_valid;
    logic               din;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr;
    logic               y;
    logic               y_q;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    // Reject nonsensical widths at elaboration.
    if (MAX_LEN < 2 || CNT_W < 1 || LEN_W < 1) begin : g_param_check
        $error("seq_det_param_if: illegal parameter combination");
    end

    // Driver side (stream source / register block).
    modport master (
        output din_valid, din, cfg_pattern, cfg_len, cfg_overlap, clr,
        input  y, y_q
`ifdef SEQ_DET_MATCH_CNT_EN
        , input match_cnt
`endif
    );

    // Detector side.
    modport slave (
        input  din_valid, din, cfg_pattern, cfg_len, cfg_overlap, clr,
        output y, y_q
`ifdef SEQ_DET_MATCH_CNT_EN
        , output match_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/seq_det_hist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_det_hist                                                 |
// | Description : History shift register (newest bit in bit 0) plus a         |
// |               saturating fill counter with shift / clear / restart.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               shift_en,
    input  wire logic               din,
    input  wire logic               clear,
    input  wire logic               restart,
    output logic      [MAX_LEN-2:0] hist,
    output logic      [LEN_W-1:0]   fill
);

    localparam int HW = MAX_LEN - 1;

    logic [HW-1:0]    hist_d, hist_q;
    logic [LEN_W-1:0] fill_d, fill_q;

    // Next history / fill: clear wins; a restart zeroes fill but hist still shifts.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = (hist_q << 1) | HW'(din);
            if (restart) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule
`default_nettype wire

// File: rtl/seq_det_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_det_param                                                |
// | Description : Runtime-programmable serial sequence detector. Mealy match  |
// |               strobe y plus registered copy y_q; overlapping or           |
// |               non-overlapping matches. Define SEQ_DET_MATCH_CNT_EN to add |
// |               a saturating match counter (match_cnt).                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = len_width(MAX_LEN),
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  wire logic       clk,
    input  wire logic       reset,
    seq_det_param_if.slave  bus
);

    if (MAX_LEN < 2 || CNT_W < 1 || LEN_W < 1) begin : g_param_check
        $error("seq_det_param: illegal parameter combination");
    end

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               legal_len;
    logic               fill_ok;
    logic               pat_hit;
    logic               y_comb;
    logic               restart;
    ovl_mode_e          mode;
    logic               y_d, y_q;

    seq_det_hist #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .shift_en (bus.din_valid),
        .din      (bus.din),
        .clear    (bus.clr),
        .restart  (restart),
        .hist     (hist),
        .fill     (fill)
    );

    // Compare the candidate window (history + current bit) against the pattern.
    always_comb begin
        cand = {hist, bus.din};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(bus.cfg_len));
        end
        legal_len = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
        // fill >= cfg_len-1 without underflow when cfg_len is 0
        fill_ok   = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, bus.cfg_len};
        pat_hit   = ((cand ^ bus.cfg_pattern) & mask) == '0;
        y_comb    = reset & ~bus.clr & bus.din_valid & legal_len & fill_ok & pat_hit;
        mode      = ovl_mode_e'(bus.cfg_overlap);
        restart   = y_comb && (mode == MODE_NONOVL);
        y_d       = y_comb;
    end

    // Registered copy of the match strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.y   = y_comb;
    assign bus.y_q = y_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Saturating match counter; clr beats a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (y_comb && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_det_param                                             |
// | Description : Scoreboard bench for seq_det_param: directed scenarios plus |
// |               randomized traffic against a queue-based reference model.    |
// |               Honours SEQ_DET_MATCH_CNT_EN for the counter checks.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_seq_det_param;
    import seq_det_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = len_width(MAX_LEN);
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic       y;
        logic       yq;
        int         cnt;
    } exp_t;

    logic clk;
    logic reset;

    seq_det_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_det_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: qualified bits received since the last reset/clr/restart.
    bit   hq[$];
    logic m_yq  = 1'b0;
    int   m_cnt = 0;

    // Configuration to apply with the next driven cycle.
    logic [MAX_LEN-1:0] n_pat = '0;
    logic [LEN_W-1:0]   n_len = '0;
    logic               n_ovl = 1'b0;

    function automatic logic model_y();
        int L;
        bit b;
        L = int'(bus.cfg_len);
        if (reset !== 1'b1 || bus.clr || !bus.din_valid) return 1'b0;
        if (L < 1 || L > MAX_LEN) return 1'b0;
        if (hq.size() < L - 1) return 1'b0;
        for (int i = 0; i < L; i++) begin
            b = (i == 0) ? bus.din : hq[hq.size() - i];
            if (b != bus.cfg_pattern[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_cfg(input logic [MAX_LEN-1:0] p, input int len, input logic ovl);
        n_pat = p;
        n_len = LEN_W'(len);
        n_ovl = ovl;
    endtask

    task automatic step(input logic rst_v, input logic valid_v, input logic din_v, input logic clr_v);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst_v;
        bus.din_valid   = valid_v;
        bus.din         = din_v;
        bus.clr         = clr_v;
        bus.cfg_pattern = n_pat;
        bus.cfg_len     = n_len;
        bus.cfg_overlap = n_ovl;
        e.y   = model_y();
        e.yq  = m_yq;
        e.cnt = m_cnt;
        sb.push_back(e);
        // Advance the model to the state after the coming edge.
        if (!rst_v) begin
            hq.delete();
            m_yq  = 1'b0;
            m_cnt = 0;
        end else begin
            m_yq = e.y;
            if (clr_v) begin
                hq.delete();
                m_cnt = 0;
            end else if (valid_v) begin
                if (e.y && m_cnt < CNT_MAX) m_cnt++;
                if (e.y && !n_ovl) begin
                    hq.delete();
                end else begin
                    hq.push_back(din_v);
                    if (hq.size() > MAX_LEN) void'(hq.pop_front());
                end
            end
        end
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, 1'b1, bits[i], 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pop one expectation per driven cycle and compare away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (bus.y !== e.y) $display("FAIL y: got %b want %b at %0t", bus.y, e.y, $time);
                else n_pass++;
                n_total++;
                if (bus.y_q !== e.yq) $display("FAIL y_q: got %b want %b at %0t", bus.y_q, e.yq, $time);
                else n_pass++;
`ifdef SEQ_DET_MATCH_CNT_EN
                n_total++;
                if (int'(bus.match_cnt) != e.cnt || $isunknown(bus.match_cnt))
                    $display("FAIL match_cnt: got %0d want %0d at %0t", bus.match_cnt, e.cnt, $time);
                else n_pass++;
`endif
            end
        end
    end

    initial begin
        int k;
        reset = 1'b0;
        bus.din_valid = 1'b0; bus.din = 1'b0; bus.clr = 1'b0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;

        // Reset with a qualified bit present: y must stay 0.
        set_cfg(8'b0000_0001, 1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // 111000, non-overlap.
        set_cfg(8'b0011_1000, 6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(16'b111000, 6);
        idle(2);

        // 101 on 1,0,1,0,1 in both modes.
        set_cfg(8'b0000_0101, 3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(16'b10101, 5);
        set_cfg(8'b0000_0101, 3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(16'b10101, 5);
        idle(1);

        // 111000 with invalid gaps of 1..3 cycles.
        set_cfg(8'b0011_1000, 6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 5; i >= 0; i--) begin
            step(1'b1, 1'b1, (i >= 3), 1'b0);
            idle((i % 3) + 1);
        end

        // clr mid-pattern, then a clean pattern.
        send_bits(16'b1110, 4);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        send_bits(16'b00, 2);
        send_bits(16'b111000, 6);
        idle(1);

        // Reset mid-pattern with din=0 qualified.
        send_bits(16'b11100, 5);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(16'b0, 1);
        send_bits(16'b111000, 6);

        // len=1, pattern 1: every qualified 1 matches, counter saturates.
        set_cfg(8'b0000_0001, 1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(16'b11111, 5);
        set_cfg(8'b0000_0001, 1, 1'b0);
        send_bits(16'b10110, 5);

        // Illegal lengths: never a match.
        set_cfg(8'b0000_0000, 0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'($urandom), 1'b0);
        set_cfg(8'hFF, 9, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0);

        // Full-length pattern.
        set_cfg(8'b1011_0010, 8, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(16'b1011_0010_1100_1011, 16);

        // Randomized traffic with periodic reconfiguration (no flush on change).
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 0) begin
                k = $urandom_range(0, 9);
                if (k > 4 && $urandom_range(0, 1) == 1) k = $urandom_range(1, 3);
                set_cfg(MAX_LEN'($urandom), k, 1'($urandom));
            end
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom),
                 ($urandom_range(0, 49) == 0));
        end
        idle(2);

        @(negedge clk);
        #1;
        n_total++;
        if (sb.size() != 0) $display("FAIL drain: %0d expectations left, want 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
